uart_receiver: RTL and testbench

UART receive engine, the counterpart to the transmitter: it recovers 8N1 frames from the serial line `Rx` and presents each byte on `RxData` with a one-cycle `RxDone` strobe. Bit timing comes from an external 16x-oversampling `tick`, produced by the existing `BaudRateGenerator` configured for 16 × `BaudRate`. Received bytes feed the register-bank write path.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_receiver_if.sv | 23 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_receiver.sv | 180 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver state encoding, oversampling
//               constants and the three-sample majority vote helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE  = 16;  // ticks per bit
  localparam int DATA_BITS   = 8;   // payload bits per frame
  localparam int TICK_CENTRE = 7;   // tick index of the start-bit centre

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_t;

  // Majority of three samples; rejects a single-tick disturbance on the line.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver_if
// Description : Bundle of the receiver's serial input, timing strobe, enable
//               and received-byte outputs. master = line/tick source side,
//               slave = the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if;
  logic       tick;
  logic       RxEn;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       ParityErr;

  modport master (output tick, RxEn, Rx,
                  input  RxData, RxDone, FrameErr, ParityErr);
  modport slave  (input  tick, RxEn, Rx,
                  output RxData, RxDone, FrameErr, ParityErr);
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the asynchronous serial line.
//               Both flops reset to 1 so the line reads idle out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  wire logic Clk,
  input  wire logic Reset,
  input  wire logic i_d,
  output logic      o_q
);

  logic r_meta;
  logic r_sync;

  // Two-stage resynchronisation of the raw line into the Clk domain.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 16x-oversampled UART receive engine (8N1, or 8E1 when the
//               UART_RX_PARITY_EN macro is defined). Each data, parity and
//               stop bit is a majority vote of three consecutive tick samples
//               taken at the bit-period wrap. Outputs are registered pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
(
  input  wire logic         Clk,
  input  wire logic         Reset,
  uart_receiver_if.slave    bus
);

  logic                 w_rx_s;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [3:0]           r_tcnt;
  logic [3:0]           w_tcnt_nxt;
  logic [2:0]           r_bidx;
  logic [2:0]           w_bidx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic [1:0]           r_hist;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 w_vote;
  logic                 w_wrap;
`ifdef UART_RX_PARITY_EN
  logic                 r_par;
  logic                 w_par_nxt;
  logic                 r_perr;
  logic                 w_perr_nxt;
`endif

  uart_rx_sync u_rx_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .i_d   (bus.Rx),
    .o_q   (w_rx_s)
  );

  // Vote over the two previous tick samples and the current one; the
  // decision is taken on the tick where the bit counter wraps.
  assign w_vote = maj3(r_hist[1], r_hist[0], w_rx_s);
  assign w_wrap = bus.tick && (r_tcnt == 4'(OVERSAMPLE - 1));

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Tick-sampled history of the synchronized line for the majority vote.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)         r_hist <= 2'b11;
    else if (bus.tick) r_hist <= {r_hist[0], w_rx_s};
  end

  // Next-state, counter, shift-register and output-pulse decode.
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = bus.tick ? (r_tcnt + 4'd1) : r_tcnt;
    w_bidx_nxt  = r_bidx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt   = r_par;
    w_perr_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tcnt_nxt = 4'd0;
        if (bus.tick && bus.RxEn && !w_rx_s) begin
          w_state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (bus.tick && (r_tcnt == 4'(TICK_CENTRE))) begin
          w_tcnt_nxt = 4'd0;
          w_bidx_nxt = 3'd0;
          // A line back high at the centre was only a glitch.
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
          w_bidx_nxt  = r_bidx + 3'd1;
          if (r_bidx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_wrap) begin
          w_par_nxt   = w_vote;
          w_state_nxt = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (w_wrap) begin
          w_data_nxt = r_shift;
`ifdef UART_RX_PARITY_EN
          w_perr_nxt = ^{r_shift, r_par};
`endif
          if (w_vote) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // Hold off until the line recovers so a break cannot retrigger.
        w_tcnt_nxt = 4'd0;
        if (bus.tick && w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tcnt_nxt  = 4'd0;
      end
    endcase
  end

  // Datapath registers and registered output pulses.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_tcnt  <= 4'd0;
      r_bidx  <= 3'd0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
`endif
    end else begin
      r_tcnt  <= w_tcnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
`endif
    end
  end

  assign bus.RxData   = r_data;
  assign bus.RxDone   = r_done;
  assign bus.FrameErr = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign bus.ParityErr = r_perr;
`else
  assign bus.ParityErr = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver. Frames are described in
//               a vector table; expected pulses go to a scoreboard queue and
//               are matched against pulses captured by a monitor. Hand-written
//               sequences cover glitch, break, back-to-back and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME_TICKS = 16 * (10 + int'(PAR_EN));
  localparam int NV = 8;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par;
    int         en_mode;   // 0 disabled, 1 enabled, 2 dropped after start bit
    int         gap;       // idle ticks before the frame
    logic       exp_pulse;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       done;
    logic       ferr;
    logic       perr;
    int         t;
  } obs_t;

  logic Clk;
  logic Reset;
  uart_receiver_if bus ();

  uart_receiver dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  obs_t obs_q[$];
  int   g_ticks  = 0;
  int   tdiv     = 0;
  int   dbl_cnt  = 0;
  int   hold_viol = 0;
  logic [7:0] prev_data = 8'h00;
  logic prev_any = 1'b0;
  logic [7:0] last_data;
  int   t_prev = 0;
  int   t_last = 0;
  vec_t vecs[NV];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Tick source: one Clk-wide strobe every 4 clocks.
  always @(negedge Clk) begin
    tdiv = (tdiv + 1) % 4;
    bus.tick = (tdiv == 0);
  end

  always @(posedge Clk) begin
    if (bus.tick) g_ticks <= g_ticks + 1;
  end

  // Monitor: capture every output pulse, flag double-wide pulses and RxData
  // changing outside a pulse.
  always @(negedge Clk) begin
    logic any;
    if (Reset) begin
      prev_data = bus.RxData;
      prev_any  = 1'b0;
    end else begin
      any = bus.RxDone | bus.FrameErr | bus.ParityErr;
      if (any) obs_q.push_back('{bus.RxData, bus.RxDone, bus.FrameErr, bus.ParityErr, g_ticks});
      if (any && prev_any) dbl_cnt++;
      if (!any && (bus.RxData !== prev_data)) hold_viol++;
      prev_data = bus.RxData;
      prev_any  = any;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      while (!bus.tick) @(posedge Clk);
    end
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    bus.Rx = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input int en_mode, input int extra_low);
    hold(1'b0, 16);
    if (en_mode == 2) bus.RxEn = 1'b0;
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    if (PAR_EN) hold(par, 16);
    hold(stop, 16);
    if (!stop && extra_low > 0) hold(1'b0, extra_low);
    bus.Rx = 1'b1;
  endtask

  task automatic expect_pulse(input logic [7:0] d, input logic ferr, input logic perr);
    exp_q.push_back('{d, ferr, perr});
    last_data = d;
  endtask

  // Match captured pulses against the scoreboard in order.
  task automatic drain();
    obs_t o;
    exp_t e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      t_prev = t_last;
      t_last = o.t;
      chk("pulse_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rxdata", 32'(o.data), 32'(e.data));
        chk("rxdone", 32'(o.done), 32'(!e.ferr));
        chk("frameerr", 32'(o.ferr), 32'(e.ferr));
        chk("parityerr", 32'(o.perr), 32'(e.perr));
      end
    end
    chk("missing_pulses", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    // Table: data, stop, parity bit, enable mode, gap, pulse?, ferr, perr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 20, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 1'b1, 1'b0, 1,  0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 0, 10, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 1'b0, 2, 10, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h7E, 1'b0, 1'b0, 1, 10, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 1'b1, 1, 10, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h07, 1'b1, 1'b0, 1, 10, 1'b1, 1'b0, PAR_EN};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 1, 10, 1'b1, 1'b0, 1'b0};

    Reset = 1'b1;
    bus.Rx = 1'b1;
    bus.RxEn = 1'b1;
    last_data = 8'h00;
    repeat (4) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_rxdata", 32'(bus.RxData), 32'h00);
    chk("reset_rxdone", 32'(bus.RxDone), 32'd0);
    chk("reset_frameerr", 32'(bus.FrameErr), 32'd0);
    chk("reset_parityerr", 32'(bus.ParityErr), 32'd0);
    wait_ticks(5);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      bus.RxEn = (vecs[i].en_mode != 0);
      wait_ticks(vecs[i].gap);
      if (vecs[i].exp_pulse)
        expect_pulse(vecs[i].data, vecs[i].exp_ferr, vecs[i].exp_perr);
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].par, vecs[i].en_mode, 0);
      wait_ticks(2);
      drain();
      chk("rxdata_after_vec", 32'(bus.RxData), 32'(last_data));
    end
    bus.RxEn = 1'b1;
    wait_ticks(10);

    // Short low glitch: must be rejected at the start-bit centre.
    hold(1'b0, 4);
    hold(1'b1, 30);
    drain();
    chk("glitch_rxdata", 32'(bus.RxData), 32'(last_data));

    // Break: stop bit low then line held low 40 ticks.
    expect_pulse(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1, 40);
    // send_frame released the line; confirm only the one frame error occurred
    wait_ticks(30);
    drain();
    chk("break_rxdata", 32'(bus.RxData), 32'h3C);

    // Recovery frame after the break.
    expect_pulse(8'h99, 1'b0, 1'b0);
    send_frame(8'h99, 1'b1, 1'b0, 1, 0);
    wait_ticks(2);
    drain();

    // Back-to-back frames with no idle time.
    wait_ticks(10);
    expect_pulse(8'h00, 1'b0, 1'b0);
    expect_pulse(8'hFF, 1'b0, PAR_EN);
    send_frame(8'h00, 1'b1, 1'b0, 1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 1, 0);
    wait_ticks(2);
    drain();
    chk("b2b_spacing", 32'(t_last - t_prev), 32'(FRAME_TICKS));

    // Reset in the middle of bit 4 of 0x81, then a clean frame.
    wait_ticks(10);
    begin
      logic [7:0] d;
      d = 8'h81;
      hold(1'b0, 16);
      for (int i = 0; i < 4; i++) hold(d[i], 16);
      hold(d[4], 8);
    end
    Reset = 1'b1;
    bus.Rx = 1'b1;
    last_data = 8'h00;
    #1;
    chk("abort_rxdata", 32'(bus.RxData), 32'h00);
    chk("abort_rxdone", 32'(bus.RxDone), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    wait_ticks(20);
    drain();
    expect_pulse(8'h42, 1'b0, 1'b0);
    send_frame(8'h42, 1'b1, 1'b0, 1, 0);
    wait_ticks(2);
    drain();
    chk("post_abort_rxdata", 32'(bus.RxData), 32'h42);

    wait_ticks(10);
    chk("double_pulse", 32'(dbl_cnt), 32'd0);
    chk("rxdata_hold", 32'(hold_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
